// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD entry, conversion and display paths:
// converter FSM states, digit geometry and display character codes.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int          DIGIT_W   = 4;
  localparam logic [3:0]  MAX_DIGIT = 4'd9;

  // Non-numeric glyph codes, placed above the 0..9 digit range.
  localparam logic [4:0]  CHAR_BLANK = 5'h10;
  localparam logic [4:0]  CHAR_R     = 5'h11;
  localparam logic [4:0]  CHAR_O     = 5'h12;
  localparam logic [4:0]  CHAR_G     = 5'h13;

endpackage

// File: rtl/bcd_to_bin_mul10_add.sv
// Combinational acc*10 + digit with saturation to OUT_W bits and an
// overflow flag; shared with the binary score accumulator.
module mul10_add
  import bcd_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic [OUT_W-1:0]   acc_i,
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [OUT_W-1:0]   sum_o,
  output logic               ovf_o
);

  localparam int WIDE_W = OUT_W + DIGIT_W;

  logic [WIDE_W-1:0] acc_wide;
  logic [WIDE_W-1:0] sum_wide;

  // Four spare bits hold acc*10 + 15 for any OUT_W-bit acc, so the
  // overflow test sees the full true result.
  assign acc_wide = {{DIGIT_W{1'b0}}, acc_i};
  assign sum_wide = (acc_wide << 3) + (acc_wide << 1)
                  + {{OUT_W{1'b0}}, digit_i};

  assign ovf_o = |sum_wide[WIDE_W-1:OUT_W];
  assign sum_o = ovf_o ? {OUT_W{1'b1}} : sum_wide[OUT_W-1:0];

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter: one digit per clock, MS first,
// with valid/ready handshakes on input and output.
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 5,
  parameter int OUT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] bcd_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_W-1:0]              bin_out,
  output logic                          ovf,
  output logic                          bad_digit
);

  localparam int BCD_W = DIGIT_W * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  state_e             state_q, state_d;
  logic [BCD_W-1:0]   shreg_q, shreg_d;
  logic [OUT_W-1:0]   acc_q,   acc_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic               ovf_q,   ovf_d;
  logic               bad_q,   bad_d;
  logic [OUT_W-1:0]   bin_q,   bin_d;
  logic               ovf_o_q, ovf_o_d;
  logic               bad_o_q, bad_o_d;

  logic [DIGIT_W-1:0] digit;
  logic [OUT_W-1:0]   step_sum;
  logic               step_ovf;

  assign digit = shreg_q[BCD_W-1 -: DIGIT_W];

  mul10_add #(.OUT_W(OUT_W)) u_mul10_add (
    .acc_i   (acc_q),
    .digit_i (digit),
    .sum_o   (step_sum),
    .ovf_o   (step_ovf)
  );

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    bad_d   = bad_q;
    bin_d   = bin_q;
    ovf_o_d = ovf_o_q;
    bad_o_d = bad_o_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d = bcd_in;
          acc_d   = '0;
          idx_d   = IDX_LAST;
          ovf_d   = 1'b0;
          bad_d   = 1'b0;
          state_d = CONV;
        end
      end

      CONV: begin
        // A saturated acc re-overflows on every later digit, so it stays clamped.
        acc_d   = step_sum;
        ovf_d   = ovf_q | step_ovf;
        bad_d   = bad_q | (digit > MAX_DIGIT);
        shreg_d = shreg_q << DIGIT_W;
        idx_d   = idx_q - 1'b1;
        if (idx_q == '0) begin
          bin_d   = bad_d ? '0 : step_sum;
          ovf_o_d = ovf_d & ~bad_d;
          bad_o_d = bad_d;
          state_d = DONE;
        end
      end

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      bad_q   <= 1'b0;
      bin_q   <= '0;
      ovf_o_q <= 1'b0;
      bad_o_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      bad_q   <= bad_d;
      bin_q   <= bin_d;
      ovf_o_q <= ovf_o_d;
      bad_o_q <= bad_o_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign bin_out   = bin_q;
  assign ovf       = ovf_o_q;
  assign bad_digit = bad_o_q;

endmodule
